// File: rtl/bp_table_if.sv
// ---------------------------------------------------------------------------
// bp_table_if
//   Lookup and resolve bus between the pipeline and bp_table_ctrl.
//
//   Signals:
//     lookup_pc      PC of the instruction currently in IF
//     pred_taken     prediction for lookup_pc, combinational from the table
//     resolve_valid  EX resolved a branch this cycle
//     resolve_pc     PC of the resolved branch
//     resolve_taken  actual outcome of the branch
//     resolve_pred   prediction that was used for the branch
//
//   Handshake: resolve_valid is a one-cycle strobe with no ready.
//   The controller samples resolve_* on every rising edge where
//   resolve_valid=1. It either accepts the resolution into its update
//   queue or drops and counts it. It never stalls the sender.
//
//   Modports: master = pipeline side, slave = controller side.
// ---------------------------------------------------------------------------
interface bp_table_if;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic        resolve_pred;

    modport master (
        output lookup_pc,
        output resolve_valid,
        output resolve_pc,
        output resolve_taken,
        output resolve_pred,
        input  pred_taken
    );

    modport slave (
        input  lookup_pc,
        input  resolve_valid,
        input  resolve_pc,
        input  resolve_taken,
        input  resolve_pred,
        output pred_taken
    );
endinterface

// File: rtl/bp_table_ctrl.sv
// ---------------------------------------------------------------------------
// bp_table_ctrl
//   Branch prediction controller. It owns a table of 2-bit saturating
//   counters indexed by pc[IDX_W+1:2] and answers combinational lookups.
//
//   Resolved branches are pushed into a small update queue. The queue ignores
//   stall when filling. It drains one entry into the table per non-stalled
//   cycle, so the single table write port is never contended.
//
//   Parameters:
//     IDX_W    table index width (2**IDX_W counters)
//     Q_DEPTH  update queue depth (power of two, >= 2)
//     CNT_W    width of the mispredict statistics counter
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     stall        pipeline stall; blocks queue drain only
//     bus          bp_table_if.slave (lookup + resolve bus)
//     q_full       update queue full
//     q_empty      update queue empty
//     drop_cnt     saturating count of dropped resolutions
//     mispred_cnt  saturating mispredict count
//
//   Optional feature macro: BP_STATS_EN
//     When defined, a mispredict counter register is built. When undefined,
//     mispred_cnt is tied to zero.
// ---------------------------------------------------------------------------
module bp_table_ctrl #(
    parameter int IDX_W   = 4,
    parameter int Q_DEPTH = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    bp_table_if.slave        bus,
    output logic             q_full,
    output logic             q_empty,
    output logic [7:0]       drop_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int TBL_N = 1 << IDX_W;
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt,
                                              input logic       taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       table_q [TBL_N];
    logic [1:0]       table_d [TBL_N];
    logic [IDX_W-1:0] qidx_q  [Q_DEPTH];
    logic [IDX_W-1:0] qidx_d  [Q_DEPTH];
    logic             qtk_q   [Q_DEPTH];
    logic             qtk_d   [Q_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [7:0]       drop_q, drop_d;

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic             is_full;
    logic             is_empty;
    logic             do_pop;
    logic             do_push;
    logic             do_drop;
    logic [IDX_W-1:0] res_idx;
    logic [IDX_W-1:0] head_idx;

    assign res_idx  = bus.resolve_pc[IDX_W+1:2];
    assign head_idx = qidx_q[rd_ptr_q];
    assign is_full  = (occ_q == OCC_W'(Q_DEPTH));
    assign is_empty = (occ_q == '0);

    // A pop in the same cycle frees a slot. This lets a push into a full
    // queue succeed. The empty case has no bypass: a push into an empty
    // queue waits one cycle before it can be popped.
    assign do_pop  = !is_empty && !stall;
    assign do_push = bus.resolve_valid && (!is_full || do_pop);
    assign do_drop = bus.resolve_valid && is_full && !do_pop;

    always_comb begin
        table_d  = table_q;
        qidx_d   = qidx_q;
        qtk_d    = qtk_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        drop_d   = drop_q;

        // When the queue is full, wr_ptr equals rd_ptr. The pop reads the
        // old head from the _q copy, so overwriting that slot here is safe.
        if (do_push) begin
            qidx_d[wr_ptr_q] = res_idx;
            qtk_d[wr_ptr_q]  = bus.resolve_taken;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (do_pop) begin
            table_d[head_idx] = sat_update(table_q[head_idx], qtk_q[rd_ptr_q]);
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (do_drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_N; i++) begin
                table_q[i] <= 2'b01;
            end
            for (int i = 0; i < Q_DEPTH; i++) begin
                qidx_q[i] <= '0;
                qtk_q[i]  <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= '0;
        end else begin
            table_q  <= table_d;
            qidx_q   <= qidx_d;
            qtk_q    <= qtk_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            drop_q   <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The lookup reads committed table state only; queued updates are not
    // forwarded.
    assign bus.pred_taken = table_q[bus.lookup_pc[IDX_W+1:2]][1];
    assign q_full         = is_full;
    assign q_empty        = is_empty;
    assign drop_cnt       = drop_q;

`ifdef BP_STATS_EN
    logic [CNT_W-1:0] mispred_q, mispred_d;

    // Every resolution with a wrong prediction is counted, including those
    // that are then dropped from the queue.
    always_comb begin
        mispred_d = mispred_q;
        if (bus.resolve_valid && (bus.resolve_taken != bus.resolve_pred) &&
            (mispred_q != {CNT_W{1'b1}})) begin
            mispred_d = mispred_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_q <= '0;
        end else begin
            mispred_q <= mispred_d;
        end
    end

    assign mispred_cnt = mispred_q;

    logic unused_bits;
    assign unused_bits = ^{bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0],
                           bus.resolve_pc[31:IDX_W+2], bus.resolve_pc[1:0]};
`else
    assign mispred_cnt = '0;

    logic unused_bits;
    assign unused_bits = ^{bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0],
                           bus.resolve_pc[31:IDX_W+2], bus.resolve_pc[1:0],
                           bus.resolve_pred};
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Bench for bp_table_ctrl. The reference model uses an integer counter
// array and a queue of pending {index, taken} updates.
module tb_bp_table_ctrl;
  localparam int IDX_W   = 4;
  localparam int Q_DEPTH = 4;
  localparam int CNT_W   = 16;
  localparam int TBL_N   = 1 << IDX_W;
  localparam longint MIS_MAX = (longint'(1) << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic q_full, q_empty;
  logic [7:0] drop_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  always #5 clk = ~clk;

  bp_table_if bif();

  bp_table_ctrl #(.IDX_W(IDX_W), .Q_DEPTH(Q_DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .bus         (bif.slave),
    .q_full      (q_full),
    .q_empty     (q_empty),
    .drop_cnt    (drop_cnt),
    .mispred_cnt (mispred_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  int model_tab[TBL_N];
  logic [IDX_W:0] exp_q[$];  // {index, taken}
  int m_drop;
  longint m_mis;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TBL_N; i++) model_tab[i] = 1;
    exp_q.delete();
    m_drop = 0;
    m_mis = 0;
  endtask

  // This applies one clock edge using the inputs that are stable now.
  task automatic model_step();
    logic [IDX_W:0] e;
    int idx;
    bit pop_now;
    bit full_now;
    bit accept;
    pop_now  = (exp_q.size() != 0) && !stall;
    full_now = (exp_q.size() == Q_DEPTH);
    accept   = 1'b0;
    if (bif.resolve_valid) begin
      if ((bif.resolve_taken != bif.resolve_pred) && (m_mis < MIS_MAX)) m_mis++;
      if (full_now && !pop_now) begin
        if (m_drop < 255) m_drop++;
      end else begin
        accept = 1'b1;
      end
    end
    if (pop_now) begin
      e = exp_q.pop_front();
      idx = int'(e[IDX_W:1]);
      if (e[0]) model_tab[idx] = (model_tab[idx] == 3) ? 3 : model_tab[idx] + 1;
      else      model_tab[idx] = (model_tab[idx] == 0) ? 0 : model_tab[idx] - 1;
    end
    if (accept) exp_q.push_back({bif.resolve_pc[IDX_W+1:2], bif.resolve_taken});
  endtask

  function automatic logic [63:0] exp_mis();
`ifdef BP_STATS_EN
    return 64'(m_mis);
`else
    return 64'd0;
`endif
  endfunction

  // Compare process. On each falling edge it checks the outputs against
  // the model state after the last rising edge. It then advances the model
  // with the inputs that the next rising edge will sample.
  always begin
    @(negedge clk);
    if (!rst_n) model_reset();
    chk("pred_taken", 64'(bif.pred_taken),
        64'(model_tab[bif.lookup_pc[IDX_W+1:2]] >= 2));
    chk("q_full", 64'(q_full), 64'(exp_q.size() == Q_DEPTH));
    chk("q_empty", 64'(q_empty), 64'(exp_q.size() == 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("mispred_cnt", 64'(mispred_cnt), exp_mis());
    if (rst_n) model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit rv, input logic [31:0] pc, input bit tk,
                     input bit pd, input bit st);
    bif.resolve_valid = rv;
    bif.resolve_pc    = pc;
    bif.resolve_taken = tk;
    bif.resolve_pred  = pd;
    stall             = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, st);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stall_left;
    model_reset();
    bif.lookup_pc     = 32'h0;
    bif.resolve_valid = 1'b0;
    bif.resolve_pc    = 32'h0;
    bif.resolve_taken = 1'b0;
    bif.resolve_pred  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    bif.lookup_pc = 32'h00; #1 chk("rst_pred_00", 64'(bif.pred_taken), 64'd0);
    bif.lookup_pc = 32'h3C; #1 chk("rst_pred_3c", 64'(bif.pred_taken), 64'd0);
    chk("rst_q_empty", 64'(q_empty), 64'd1);
    chk("rst_q_full", 64'(q_full), 64'd0);

    // Two taken resolutions on pc 0x10 (index 4)
    bif.lookup_pc = 32'h10;
    cyc(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    chk("t2_weak_t_pred", 64'(bif.pred_taken), 64'd1);
    idle(1, 1'b0);
    chk("t2_q_empty", 64'(q_empty), 64'd1);
    chk("t2_pred", 64'(bif.pred_taken), 64'd1);
    chk("t2_model_cnt", 64'(model_tab[4]), 64'd3);

    // Five not-taken resolutions saturate the counter at 00
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    chk("t3_pred", 64'(bif.pred_taken), 64'd0);
    chk("t3_model_cnt", 64'(model_tab[4]), 64'd0);

    // A held stall fills the queue, and the two extra resolutions are dropped
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 32'(i * 4 + 32), 1'b1, 1'b1, 1'b1);
      if (i == 3) chk("t4_full_after4", 64'(q_full), 64'd1);
    end
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t4_q_full", 64'(q_full), 64'd1);
    idle(3, 1'b0);
    chk("t4_not_empty_3", 64'(q_empty), 64'd0);
    idle(1, 1'b0);
    chk("t4_empty_4", 64'(q_empty), 64'd1);

    // A push and a pop in the same cycle on a full queue: no drop
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 32'h3C, 1'b0, 1'b0, 1'b0);
    chk("t5_drop_same", 64'(drop_cnt), 64'd2);
    chk("t5_q_full", 64'(q_full), 64'd1);
    idle(5, 1'b0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
    chk("t7_pre_not_empty", 64'(q_empty), 64'd0);
    bif.resolve_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t7_q_empty", 64'(q_empty), 64'd1);
    chk("t7_q_full", 64'(q_full), 64'd0);
    chk("t7_drop", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < TBL_N; i++) begin
      bif.lookup_pc = 32'(i * 4);
      @(posedge clk);
      #1 chk("t7_pred_zero", 64'(bif.pred_taken), 64'd0);
    end
    stall = 1'b0;
    rst_n = 1'b1;

    // Mispredict statistics: three wrong predictions, two correct
    cyc(1'b1, 32'h04, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h08, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h0C, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
`ifdef BP_STATS_EN
    chk("t6_mispred", 64'(mispred_cnt), 64'd3);
`else
    chk("t6_mispred", 64'(mispred_cnt), 64'd0);
`endif

    // Randomized traffic with stall bursts
    stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      bit st;
      if (stall_left > 0) begin
        stall_left--;
        st = 1'b1;
      end else if ($urandom_range(0, 9) == 0) begin
        stall_left = $urandom_range(1, 12);
        st = 1'b1;
      end else begin
        st = 1'b0;
      end
      bif.lookup_pc = $urandom;
      cyc($urandom_range(0, 9) < 7, $urandom, 1'($urandom), 1'($urandom), st);
    end
    idle(6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
